// File: rtl/io_ctrl_pkg.sv
// Shared definitions for the basic-computer I/O controller:
// output FSM encoding, flag reset values and the default data width.
package io_ctrl_pkg;

  localparam int DATA_W_DEF = 8;

  // FGO resets high so the CPU sees the printer as ready after reset.
  localparam logic FGO_RST = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } out_state_e;

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO buffering input-device words ahead of INPR.
// The head word is read combinationally on dout; pointers wrap at the power-of-two depth.
module io_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int AW         = $clog2(FIFO_DEPTH),
  parameter int CW         = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     cnt_q,  cnt_d;

  assign full  = (cnt_q == CW'(FIFO_DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign dout  = mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset; the empty count guards stale entries.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/io_ctrl.sv
// I/O controller: owns INPR/OUTR and FGI/FGO, refills INPR from the input FIFO
// and hands OUTR to the output device through a two-state valid/ready FSM.
module io_ctrl
  import io_ctrl_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic [DATA_W-1:0] ac_low,
  input  logic              inp_rd,
  input  logic              out_wr,
  output logic [DATA_W-1:0] inpr,
  output logic              fgi,
  output logic              fgo,
  output logic              int_req,
  output logic [CW-1:0]     fifo_count,
  output logic              out_err
);

  out_state_e        state_q, state_d;
  logic [DATA_W-1:0] inpr_q, inpr_d;
  logic [DATA_W-1:0] outr_q, outr_d;
  logic              fgi_q, fgi_d;
  logic              fgo_q, fgo_d;
  logic              err_q, err_d;

  logic              push, pop, full, empty, load, done;
  logic [DATA_W-1:0] head;

  assign push = in_valid && !full;
  // Refill only from a registered-low FGI, so an INP always leaves one low cycle.
  assign pop  = !fgi_q && !empty;

  io_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (in_data),
    .dout  (head),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (out_wr && fgo_q) state_d = ST_SEND;
      ST_SEND: if (out_ready)       state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == ST_SEND);
    load      = (state_q == ST_IDLE) && out_wr && fgo_q;
    done      = (state_q == ST_SEND) && out_ready;
  end

  always_comb begin
    inpr_d = inpr_q;
    fgi_d  = fgi_q;
    outr_d = outr_q;
    fgo_d  = fgo_q;
    err_d  = err_q | (out_wr & ~fgo_q);
    if (pop) begin
      inpr_d = head;
      fgi_d  = 1'b1;
    end else if (inp_rd && fgi_q) begin
      fgi_d  = 1'b0;
    end
    if (load) begin
      outr_d = ac_low;
      fgo_d  = 1'b0;
    end else if (done) begin
      fgo_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inpr_q <= '0;
      fgi_q  <= 1'b0;
      outr_q <= '0;
      fgo_q  <= FGO_RST;
      err_q  <= 1'b0;
    end else begin
      inpr_q <= inpr_d;
      fgi_q  <= fgi_d;
      outr_q <= outr_d;
      fgo_q  <= fgo_d;
      err_q  <= err_d;
    end
  end

  assign in_ready = !full;
  assign inpr     = inpr_q;
  assign fgi      = fgi_q;
  assign fgo      = fgo_q;
  assign out_data = outr_q;
  assign out_err  = err_q;
  assign int_req  = fgi_q | fgo_q;

endmodule
